// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: widths, serializer states and the
// encode / error-injection helpers used by both link endpoints.
package ham_pkg;

    localparam int CW_W = 7;
    localparam int D_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Positions 1..7 map to c[0..6]; parity bits sit at the power-of-two positions
    // so that a receiver syndrome equals the 1-based index of a flipped bit.
    function automatic logic [CW_W-1:0] ham74_encode(input logic [D_W-1:0] d);
        logic [CW_W-1:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // pos = 0 leaves the word alone; pos = 1..7 flips c[pos-1].
    function automatic logic [CW_W-1:0] ham74_inject(input logic [CW_W-1:0] c,
                                                     input logic [2:0]      pos);
        logic [CW_W-1:0] r;
        r = c;
        for (int i = 0; i < CW_W; i++) begin
            if (pos == 3'(i + 1)) begin
                r[i] = ~r[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ham_tx_serializer_if.sv
// Data handshake and transmit-side outputs of the Hamming serializer.
// master = upstream producer / observer, slave = the serializer itself.
interface ham_tx_serializer_if;
    import ham_pkg::*;

    logic [D_W-1:0]  d_in;
    logic            d_valid;
    logic            d_ready;
    logic [2:0]      inj_pos;
    logic [CW_W-1:0] cw;
    logic            cw_valid;
    logic            tx_bit;
    logic            tx_frame;

    modport master (
        output d_in, d_valid, inj_pos,
        input  d_ready, cw, cw_valid, tx_bit, tx_frame
    );

    modport slave (
        input  d_in, d_valid, inj_pos,
        output d_ready, cw, cw_valid, tx_bit, tx_frame
    );
endinterface

// File: rtl/ham74_enc.sv
// Combinational Hamming(7,4) encoder; thin wrapper so the package function
// can be instantiated and tested on its own.
module ham74_enc
    import ham_pkg::*;
(
    input  logic [D_W-1:0]  i_d,
    output logic [CW_W-1:0] o_c
);

    // Pure encode, no state.
    always_comb begin
        o_c = ham74_encode(i_d);
    end

endmodule

// File: rtl/ham_tx_serializer.sv
// Hamming(7,4) transmit stage: accepts 4-bit words, encodes (with optional
// single-bit error injection), presents the codeword in parallel and shifts
// it out framed on tx_bit/tx_frame, followed by a configurable idle gap.
module ham_tx_serializer
    import ham_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ham_tx_serializer_if.slave   bus
);

    // With no gap the last SHIFT cycle can take the next word, giving
    // contiguous frames.
    localparam bit       B2B      = (GAP_CYCLES == 0);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [CW_W-1:0] r_shift;
    logic [CW_W-1:0] w_shift_next;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_next;
    logic [3:0]      r_gap_cnt;
    logic [3:0]      w_gap_cnt_next;
    logic [CW_W-1:0] r_cw;
    logic [CW_W-1:0] w_cw_next;
    logic            r_cw_valid;
    logic            w_cw_valid_next;
    logic            r_tx_bit;
    logic            w_tx_bit_next;
    logic            r_tx_frame;
    logic            w_tx_frame_next;

    logic [CW_W-1:0] w_enc;
    logic [CW_W-1:0] w_inj;
    logic            w_last_bit;
    logic            w_ready;
    logic            w_accept;

    ham74_enc u_enc (
        .i_d (bus.d_in),
        .o_c (w_enc)
    );

    assign w_inj      = ham74_inject(w_enc, bus.inj_pos);
    assign w_last_bit = (r_bit_idx == 3'd6);
    // Ready depends on state only; held low while reset is asserted.
    assign w_ready    = rst_n && ((r_state == IDLE) ||
                                  (B2B && (r_state == SHIFT) && w_last_bit));
    assign w_accept   = bus.d_valid && w_ready;

    // State register and all registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_gap_cnt  <= '0;
            r_cw       <= '0;
            r_cw_valid <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_tx_frame <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_cw       <= w_cw_next;
            r_cw_valid <= w_cw_valid_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_frame <= w_tx_frame_next;
        end
    end

    // Next-state selection for IDLE -> SHIFT -> (GAP | SHIFT | IDLE).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_last_bit) begin
                    if (!B2B)          w_state_next = GAP;
                    else if (w_accept) w_state_next = SHIFT;
                    else               w_state_next = IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath next values: load on accept, otherwise walk the shift register.
    // The bit for the coming cycle is registered, so the first bit appears
    // together with cw_valid one cycle after the accepting edge.
    always_comb begin
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_gap_cnt_next  = '0;
        w_cw_next       = r_cw;
        w_cw_valid_next = 1'b0;
        w_tx_bit_next   = 1'b0;
        w_tx_frame_next = 1'b0;
        if (w_accept) begin
            w_shift_next    = w_inj;
            w_bit_idx_next  = 3'd0;
            w_cw_next       = w_inj;
            w_cw_valid_next = 1'b1;
            w_tx_bit_next   = LSB_FIRST ? w_inj[0] : w_inj[CW_W-1];
            w_tx_frame_next = 1'b1;
        end else if ((r_state == SHIFT) && !w_last_bit) begin
            w_shift_next    = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
            w_bit_idx_next  = r_bit_idx + 3'd1;
            w_tx_bit_next   = LSB_FIRST ? r_shift[1] : r_shift[CW_W-2];
            w_tx_frame_next = 1'b1;
        end
        if (r_state == GAP) begin
            w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
    end

    assign bus.d_ready  = w_ready;
    assign bus.cw       = r_cw;
    assign bus.cw_valid = r_cw_valid;
    assign bus.tx_bit   = r_tx_bit;
    assign bus.tx_frame = r_tx_frame;

endmodule

// File: tb/tb_ham_tx_serializer.sv
// Directed bench for ham_tx_serializer: one instance with a 1-cycle gap and
// LSB-first order, one back-to-back MSB-first. A scoreboard queues the
// expected codeword and serial bits at each accept and checks them as the
// DUT emits them.
module tb_ham_tx_serializer;
    import ham_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ham_tx_serializer_if a ();
    ham_tx_serializer_if b ();

    ham_tx_serializer #(.GAP_CYCLES(1), .LSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    ham_tx_serializer #(.GAP_CYCLES(0), .LSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] cwq_a[$];
    logic [6:0] cwq_b[$];
    bit         bitq_a[$];
    bit         bitq_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from the position rule: parity bit at 2^k covers
    // every position whose index has bit k set.
    function automatic logic [6:0] m_enc(input logic [3:0] d);
        logic [7:1] w;
        w    = '0;
        w[3] = d[0];
        w[5] = d[1];
        w[6] = d[2];
        w[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= 7; p++) begin
                if (((p >> k) & 1) == 1 && p != (1 << k)) par ^= w[p];
            end
            w[1 << k] = par;
        end
        return w[7:1];
    endfunction

    function automatic logic [6:0] m_inj(input logic [6:0] c, input logic [2:0] p);
        logic [6:0] one;
        one = 7'd1;
        return (p == 3'd0) ? c : (c ^ (one << (p - 3'd1)));
    endfunction

    function automatic logic [2:0] m_syn(input logic [6:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= 3'(p);
        return s;
    endfunction

    function automatic logic [3:0] m_fix(input logic [6:0] c);
        logic [6:0] r;
        logic [2:0] s;
        r = c;
        s = m_syn(c);
        if (s != 3'd0) r[s-3'd1] = ~r[s-3'd1];
        return {r[6], r[5], r[4], r[2]};
    endfunction

    // Scoreboard for the LSB-first, gapped instance.
    always @(negedge clk) begin
        logic [6:0] e;
        if (a.cw_valid === 1'b1) begin
            if (cwq_a.size() == 0) chk("a.cw_extra", 32'(a.cw_valid), 32'd0);
            else begin
                e = cwq_a.pop_front();
                chk("a.cw", 32'(a.cw), 32'(e));
            end
        end
        if (a.tx_frame === 1'b1) begin
            if (bitq_a.size() == 0) chk("a.frame_extra", 32'(a.tx_frame), 32'd0);
            else chk("a.tx_bit", 32'(a.tx_bit), 32'(bitq_a.pop_front()));
        end else begin
            chk("a.tx_bit_idle", 32'(a.tx_bit), 32'd0);
        end
        if (rst_n && a.d_valid && a.d_ready) begin
            e = m_inj(m_enc(a.d_in), a.inj_pos);
            cwq_a.push_back(e);
            for (int i = 0; i < 7; i++) bitq_a.push_back(e[i]);
        end
        if (!rst_n) begin
            cwq_a.delete();
            bitq_a.delete();
        end
    end

    // Scoreboard for the MSB-first, back-to-back instance.
    always @(negedge clk) begin
        logic [6:0] e;
        if (b.cw_valid === 1'b1) begin
            if (cwq_b.size() == 0) chk("b.cw_extra", 32'(b.cw_valid), 32'd0);
            else begin
                e = cwq_b.pop_front();
                chk("b.cw", 32'(b.cw), 32'(e));
            end
        end
        if (b.tx_frame === 1'b1) begin
            if (bitq_b.size() == 0) chk("b.frame_extra", 32'(b.tx_frame), 32'd0);
            else chk("b.tx_bit", 32'(b.tx_bit), 32'(bitq_b.pop_front()));
        end else begin
            chk("b.tx_bit_idle", 32'(b.tx_bit), 32'd0);
        end
        if (rst_n && b.d_valid && b.d_ready) begin
            e = m_inj(m_enc(b.d_in), b.inj_pos);
            cwq_b.push_back(e);
            for (int i = 0; i < 7; i++) bitq_b.push_back(e[6-i]);
        end
        if (!rst_n) begin
            cwq_b.delete();
            bitq_b.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return just after the accepting edge (cycle k+1).
    task automatic send_a(input logic [3:0] d, input logic [2:0] p, input bit hold);
        bit got;
        got = 1'b0;
        a.d_in = d; a.inj_pos = p; a.d_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            got = a.d_ready;
            tick();
        end
        if (!hold) a.d_valid = 1'b0;
        chk("a.accept", 32'(got), 32'd1);
    endtask

    task automatic send_b(input logic [3:0] d, input logic [2:0] p, input bit hold);
        bit got;
        got = 1'b0;
        b.d_in = d; b.inj_pos = p; b.d_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            got = b.d_ready;
            tick();
        end
        if (!hold) b.d_valid = 1'b0;
        chk("b.accept", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        a.d_in = '0; a.d_valid = 1'b0; a.inj_pos = '0;
        b.d_in = '0; b.d_valid = 1'b0; b.inj_pos = '0;

        // Reset state, observed while rst_n is still low.
        rst_n = 1'b0;
        tick(); tick();
        chk("rst.d_ready",  32'(a.d_ready),  32'd0);
        chk("rst.cw",       32'(a.cw),       32'd0);
        chk("rst.cw_valid", 32'(a.cw_valid), 32'd0);
        chk("rst.tx_frame", 32'(a.tx_frame), 32'd0);
        chk("rst.tx_bit",   32'(a.tx_bit),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.d_ready",  32'(a.d_ready),  32'd1);

        // Single word, no injection; ready low for 7 SHIFT + 1 GAP cycles.
        send_a(4'b1011, 3'd0, 1'b0);
        chk("t1.cw",       32'(a.cw),       32'h55);
        chk("t1.cw_valid", 32'(a.cw_valid), 32'd1);
        chk("t1.tx_frame", 32'(a.tx_frame), 32'd1);
        chk("t1.tx_bit0",  32'(a.tx_bit),   32'd1);
        n = 0;
        for (int t = 0; t < 20 && !a.d_ready; t++) begin
            n++;
            if (n == 2) chk("t1.cw_valid_pulse", 32'(a.cw_valid), 32'd0);
            tick();
        end
        chk("t1.ready_low_cycles", 32'(n), 32'd8);

        // Valid held high across two words; nothing lost or duplicated.
        send_a(4'b0001, 3'd0, 1'b1);
        chk("t2.cw0", 32'(a.cw), 32'h07);
        send_a(4'b1111, 3'd0, 1'b0);
        chk("t2.cw1", 32'(a.cw), 32'h7F);
        repeat (10) tick();

        // Error injection: syndrome must equal the injected position.
        send_a(4'b1011, 3'd3, 1'b0);
        chk("t3.cw",   32'(a.cw),        32'h51);
        chk("t3.syn",  32'(m_syn(a.cw)), 32'd3);
        chk("t3.data", 32'(m_fix(a.cw)), 32'hB);
        for (int p = 1; p <= 7; p++) begin
            logic [3:0] d;
            d = 4'(p * 3);
            send_a(d, 3'(p), 1'b0);
            chk("t3.sweep_syn",  32'(m_syn(a.cw)), 32'(p));
            chk("t3.sweep_data", 32'(m_fix(a.cw)), 32'(d));
        end
        repeat (10) tick();

        // Reset in the 4th SHIFT cycle aborts the frame.
        send_a(4'b0001, 3'd0, 1'b0);
        tick(); tick(); tick();
        chk("t5.in_frame", 32'(a.tx_frame), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5.cw",       32'(a.cw),          32'd0);
        chk("t5.cw_valid", 32'(a.cw_valid),    32'd0);
        chk("t5.tx_frame", 32'(a.tx_frame),    32'd0);
        chk("t5.tx_bit",   32'(a.tx_bit),      32'd0);
        chk("t5.d_ready",  32'(a.d_ready),     32'd0);
        chk("t5.state",    32'(dut_a.r_state), 32'(IDLE));
        rst_n = 1'b1;
        #1;
        chk("t5.ready_rel", 32'(a.d_ready), 32'd1);
        send_a(4'b0001, 3'd0, 1'b0);
        chk("t5.cw_new", 32'(a.cw), 32'h07);
        repeat (10) tick();

        // Idle after reset: nothing moves for 20 cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            if (a.d_ready !== 1'b1 || a.tx_frame !== 1'b0 ||
                a.cw !== 7'd0 || a.cw_valid !== 1'b0) bad++;
            tick();
        end
        chk("t6.idle_bad_cycles", 32'(bad), 32'd0);

        // Back-to-back MSB-first: 14 contiguous frame cycles, zeros then ones.
        send_b(4'b0000, 3'd0, 1'b1);
        b.d_in = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            chk("t4.tx_frame", 32'(b.tx_frame), 32'd1);
            chk("t4.tx_bit",   32'(b.tx_bit),   (i < 7) ? 32'd0 : 32'd1);
            chk("t4.d_ready",  32'(b.d_ready),  (i == 6 || i == 13) ? 32'd1 : 32'd0);
            tick();
            if (i == 6) b.d_valid = 1'b0;
        end
        chk("t4.frame_end", 32'(b.tx_frame), 32'd0);
        chk("t4.ready_idle", 32'(b.d_ready), 32'd1);

        // MSB-first order on an asymmetric word: 0,0,0,0,1,1,1.
        send_b(4'b0001, 3'd0, 1'b0);
        chk("t4.msb_first0", 32'(b.tx_bit), 32'd0);
        repeat (4) tick();
        chk("t4.msb_first4", 32'(b.tx_bit), 32'd1);
        repeat (6) tick();

        chk("end.a_cw_queue",  32'(cwq_a.size()),  32'd0);
        chk("end.a_bit_queue", 32'(bitq_a.size()), 32'd0);
        chk("end.b_cw_queue",  32'(cwq_b.size()),  32'd0);
        chk("end.b_bit_queue", 32'(bitq_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
